// File: rtl/ysyx_23060187_core_ctrl_if.sv
// Fetch/LSU handshake bundle between the core sequencer and its memory-side units.
// Latency: none, wires only.
// Backpressure: req_valid held until req_ready; responses are single-cycle pulses.
interface ysyx_23060187_core_ctrl_if;
  logic ifu_req_valid;
  logic ifu_req_ready;
  logic ifu_rsp_valid;
  logic lsu_req_valid;
  logic lsu_req_ready;
  logic lsu_we;
  logic lsu_rsp_valid;

  // sequencer side: issues requests, consumes readies and responses
  modport master (
    output ifu_req_valid, lsu_req_valid, lsu_we,
    input  ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid
  );

  // IFU/LSU side
  modport slave (
    input  ifu_req_valid, lsu_req_valid, lsu_we,
    output ifu_req_ready, ifu_rsp_valid, lsu_req_ready, lsu_rsp_valid
  );
endinterface

// File: rtl/ysyx_23060187_core_ctrl.sv
// Multi-cycle NPC sequencer: fetch -> decode -> exec -> mem -> writeback, stops on ebreak/illegal/timeout.
// Latency: 5 cycles per ALU instruction with zero-wait IFU; loads/stores add MEM_REQ + MEM_WAIT cycles.
// Backpressure: holds req_valid until ready; waits for rsp up to TIMEOUT cycles, then traps to ERROR.
module ysyx_23060187_core_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [11:0]          sys_imm,
  ysyx_23060187_core_ctrl_if.master bus,
  output logic                 ir_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic                 halt,
  output logic                 err,
  output logic [CNT_W-1:0]     instret
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH_REQ, S_FETCH_WAIT, S_DECODE, S_EXEC,
    S_MEM_REQ, S_MEM_WAIT, S_WB, S_HALT, S_ERROR
  } state_e;

  // instruction class captured in DECODE; later states never look at opcode again
  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_BRANCH = 3'd3,
    CL_SYS    = 3'd4
  } cls_e;

  localparam int unsigned WCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_e            state_q, state_d;
  cls_e              cls_q, cls_d;
  logic [WCNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0]  instret_q;
  logic              halt_q, err_q;

  logic ifu_req_c, lsu_req_c, lsu_we_c, ir_we_c, rf_we_c, pc_we_c;
  logic retire, timeout_hit, in_wait, rsp_now;

  assign in_wait     = (state_q == S_FETCH_WAIT) || (state_q == S_MEM_WAIT);
  assign rsp_now     = (state_q == S_FETCH_WAIT) ? bus.ifu_rsp_valid : bus.lsu_rsp_valid;
  assign timeout_hit = (TIMEOUT != 0) && (wcnt_q == WCNT_LAST);

  // next-state and Moore strobes; ir_we is the only Mealy output
  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    ifu_req_c = 1'b0;
    lsu_req_c = 1'b0;
    lsu_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    retire    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH_REQ;
      S_FETCH_REQ: begin
        ifu_req_c = 1'b1;
        if (bus.ifu_req_ready) state_d = S_FETCH_WAIT;
      end
      S_FETCH_WAIT: begin
        if (bus.ifu_rsp_valid) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: begin
        case (opcode)
          7'b0010011, 7'b0110011, 7'b0110111,
          7'b0010111, 7'b1101111, 7'b1100111: begin
            cls_d   = CL_ALU;
            state_d = S_EXEC;
          end
          7'b1100011: begin
            cls_d   = CL_BRANCH;
            state_d = S_EXEC;
          end
          7'b0000011: begin
            cls_d   = CL_LOAD;
            state_d = S_EXEC;
          end
          7'b0100011: begin
            cls_d   = CL_STORE;
            state_d = S_EXEC;
          end
          7'b1110011: begin
            cls_d = CL_SYS;
            if (sys_imm == 12'd1) begin
              // ebreak retires here; it never reaches WB
              retire  = 1'b1;
              state_d = S_HALT;
            end else begin
              state_d = S_WB;
            end
          end
          default: state_d = S_ERROR;
        endcase
      end
      S_EXEC: begin
        if (cls_q == CL_LOAD || cls_q == CL_STORE) state_d = S_MEM_REQ;
        else                                       state_d = S_WB;
      end
      S_MEM_REQ: begin
        lsu_req_c = 1'b1;
        lsu_we_c  = (cls_q == CL_STORE);
        if (bus.lsu_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (bus.lsu_rsp_valid)  state_d = S_WB;
        else if (timeout_hit)   state_d = S_ERROR;
      end
      S_WB: begin
        pc_we_c = 1'b1;
        rf_we_c = !(cls_q == CL_BRANCH || cls_q == CL_STORE || cls_q == CL_SYS);
        retire  = 1'b1;
        state_d = S_FETCH_REQ;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_IDLE;
    endcase
  end

  // state and instruction-class registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cls_q   <= CL_ALU;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
    end
  end

  // wait-timeout counter, retire counter and sticky stop flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_q    <= '0;
      instret_q <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_d != state_q && (state_d == S_FETCH_WAIT || state_d == S_MEM_WAIT))
        wcnt_q <= '0;
      else if (in_wait && !rsp_now)
        wcnt_q <= wcnt_q + WCNT_W'(1);
      if (retire)             instret_q <= instret_q + CNT_W'(1);
      if (state_d == S_HALT)  halt_q    <= 1'b1;
      if (state_d == S_ERROR) err_q     <= 1'b1;
    end
  end

  // everything forced low while reset is held, not just after the reset edge
  assign bus.ifu_req_valid = !rst && ifu_req_c;
  assign bus.lsu_req_valid = !rst && lsu_req_c;
  assign bus.lsu_we        = !rst && lsu_we_c;
  assign ir_we             = !rst && ir_we_c;
  assign rf_we             = !rst && rf_we_c;
  assign pc_we             = !rst && pc_we_c;
  assign halt              = !rst && halt_q;
  assign err               = !rst && err_q;
  assign instret           = rst ? '0 : instret_q;

endmodule
